// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// Multicycle MIPS control FSM: sequences ALU, unified memory and register
// file over several cycles per instruction (lw, sw, R-type, addi, beq, j).
// Ports: clk, rst (async, active-high), op_code/funct from the IR, zero from
// the ALU, mem_ready handshake; datapath controls pc_en..alu_ctrl; sticky
// status halted/illegal/mem_err. Memory waits are bounded by MEM_TIMEOUT.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alu_ctrl,
    output logic       halted,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_BEQ    = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       is_load;
    logic       is_load_nxt;
    logic       illegal_nxt;
    logic       mem_err_nxt;
    logic       mem_wait;
    logic       timeout;
    logic       pcwrite;
    logic       branch;

    assign mem_wait = (state == S_FETCH) || (state == S_MEMRD) ||
                      (state == S_MEMWR);

    // Fires on the waiting cycle that would bring the count to the limit.
    assign timeout = mem_wait && !mem_ready &&
                     ((wait_cnt + 8'd1) >= TIMEOUT);

    always_comb begin
        state_nxt   = state;
        is_load_nxt = is_load;
        illegal_nxt = illegal;
        mem_err_nxt = mem_err;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_LW: begin
                        state_nxt   = S_MEMADR;
                        is_load_nxt = 1'b1;
                    end
                    OP_SW: begin
                        state_nxt   = S_MEMADR;
                        is_load_nxt = 1'b0;
                    end
                    OP_RTYPE: state_nxt = S_EXEC;
                    OP_ADDI:  state_nxt = S_ADDIEX;
                    OP_BEQ:   state_nxt = S_BEQ;
                    OP_J:     state_nxt = S_JUMP;
                    default: begin
                        state_nxt   = S_TRAP;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            // Opcode is only trusted in DECODE, so lw/sw is remembered there.
            S_MEMADR: state_nxt = is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_BEQ:    state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt   = S_TRAP;
            mem_err_nxt = 1'b1;
        end
    end

    always_comb begin
        wait_nxt = (mem_wait && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
        if (state_nxt != state) wait_nxt = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            is_load  <= 1'b0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            is_load  <= is_load_nxt;
            illegal  <= illegal_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alu_ctrl = 3'b000;
        case (state)
            S_FETCH: begin
                alusrcb  = 2'b01;
                alu_ctrl = 3'b010;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
            end
            S_DECODE: begin
                alusrcb  = 2'b11;
                alu_ctrl = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_ctrl = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alu_ctrl = 3'b100;
                    6'b101010: alu_ctrl = 3'b110;
                    6'b011100: alu_ctrl = 3'b101;
                    default:   alu_ctrl = 3'b010;
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQ: begin
                alusrca  = 1'b1;
                alu_ctrl = 3'b100;
                branch   = 1'b1;
                pcsrc    = 2'b01;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_en  = pcwrite | (branch & zero);
    assign halted = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Testbench for multicycle_ctrl: builds per-cycle expected output words from
// instruction-level sequences and compares every cycle.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_code = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic       alusrca, halted, illegal, mem_err;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu_ctrl;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alu_ctrl(alu_ctrl),
        .halted(halted), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, irwrite, memwrite;
        logic       regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alu_ctrl;
        logic       halted, illegal, mem_err;
    } outs_t;

    typedef struct {
        outs_t      exp;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
    } cyc_t;

    outs_t got;
    assign got = {pc_en, iord, irwrite, memwrite, regwrite, regdst,
                  memtoreg, alusrca, alusrcb, pcsrc, alu_ctrl,
                  halted, illegal, mem_err};

    cyc_t plan[$];
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00;
    localparam logic [5:0] ADDI = 6'h08, BEQ = 6'h04, J = 6'h02;

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        if (fn == 6'b100000) return 3'b010;
        if (fn == 6'b100010) return 3'b100;
        if (fn == 6'b101010) return 3'b110;
        if (fn == 6'b011100) return 3'b101;
        return 3'b010;
    endfunction

    task automatic add(input outs_t e, input logic rdy, input logic [5:0] op,
                       input logic [5:0] fn, input logic z);
        cyc_t c;
        c.exp = e; c.rdy = rdy; c.op = op; c.fn = fn; c.z = z;
        plan.push_back(c);
    endtask

    task automatic add_trap(input logic ill, input logic me);
        outs_t e = '0;
        e.halted = 1'b1; e.illegal = ill; e.mem_err = me;
        for (int i = 0; i < 3; i++) add(e, r1(), r6(), r6(), r1());
    endtask

    // A memory wait of 'waits' idle cycles, then the ready cycle, or a trap
    // if the idle run hits the timeout limit.
    task automatic add_wait(input outs_t idle_e, input outs_t done_e,
                            input int waits, output bit trapped);
        int n = (waits >= TO) ? TO : waits;
        for (int i = 0; i < n; i++) add(idle_e, 1'b0, r6(), r6(), r1());
        trapped = (waits >= TO);
        if (trapped) add_trap(1'b0, 1'b1);
        else add(done_e, 1'b1, r6(), r6(), r1());
    endtask

    task automatic add_idle();
        add('0, r1(), r6(), r6(), r1());
    endtask

    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int wf, input int wm);
        outs_t fi, fr, e;
        bit t;
        fi = '0; fi.alusrcb = 2'b01; fi.alu_ctrl = 3'b010;
        fr = fi; fr.pc_en = 1'b1; fr.irwrite = 1'b1;
        add_wait(fi, fr, wf, t);
        if (t) return;
        e = '0; e.alusrcb = 2'b11; e.alu_ctrl = 3'b010;
        add(e, r1(), op, r6(), r1());
        if (op == LW || op == SW || op == ADDI) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu_ctrl = 3'b010;
            add(e, r1(), r6(), r6(), r1());
        end
        if (op == LW) begin
            e = '0; e.iord = 1'b1;
            add_wait(e, e, wm, t);
            if (!t) begin
                e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
                add(e, r1(), r6(), r6(), r1());
            end
        end else if (op == SW) begin
            e = '0; e.iord = 1'b1; e.memwrite = 1'b1;
            add_wait(e, e, wm, t);
        end else if (op == RT) begin
            e = '0; e.alusrca = 1'b1; e.alu_ctrl = alu_of(fn);
            add(e, r1(), r6(), fn, r1());
            e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
            add(e, r1(), r6(), r6(), r1());
        end else if (op == ADDI) begin
            e = '0; e.regwrite = 1'b1;
            add(e, r1(), r6(), r6(), r1());
        end else if (op == BEQ) begin
            e = '0; e.alusrca = 1'b1; e.alu_ctrl = 3'b100;
            e.pcsrc = 2'b01; e.pc_en = z;
            add(e, r1(), r6(), r6(), z);
        end else if (op == J) begin
            e = '0; e.pc_en = 1'b1; e.pcsrc = 2'b10;
            add(e, r1(), r6(), r6(), r1());
        end else begin
            add_trap(1'b1, 1'b0);
        end
    endtask

    task automatic drive(input cyc_t c);
        op_code = c.op; funct = c.fn; zero = c.z; mem_ready = c.rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        plan.delete();
        add_idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            op_code = r6(); funct = r6(); zero = r1(); mem_ready = r1();
            @(negedge clk);
            n_chk++;
            if (got !== outs_t'('0))
                $display("FAIL reset cyc %0d got %h want %h", i, got, 18'h0);
            else n_pass++;
        end
    endtask

    task automatic test_lw();
        do_reset();
        plan_instr(LW, 6'h0, 1'b0, 0, 0);
        plan_instr(ADDI, 6'h0, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL lw cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[5] = '{6'h2a, 6'h1c, 6'h22, 6'h20, 6'h3f};
        do_reset();
        foreach (fns[k]) plan_instr(RT, fns[k], 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL rtype cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        do_reset();
        plan_instr(BEQ, 6'h0, 1'b1, 0, 0);
        plan_instr(BEQ, 6'h0, 1'b0, 0, 0);
        plan_instr(J, 6'h0, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL branch cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        do_reset();
        plan_instr(SW, 6'h0, 1'b0, 1, 3);
        plan_instr(LW, 6'h0, 1'b0, 2, 2);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL sw_wait cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        plan_instr(J, 6'h0, 1'b0, TO - 1, 0);
        plan_instr(LW, 6'h0, 1'b0, TO, 0);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL fetch_to cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_memwr_timeout();
        do_reset();
        plan_instr(SW, 6'h0, 1'b0, 0, TO);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL memwr_to cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        do_reset();
        plan_instr(6'h3f, 6'h0, 1'b0, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL illegal cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst = 1'b1; #1; n_chk++;
        if (got !== outs_t'('0))
            $display("FAIL illegal_clear got %h want %h", got, 18'h0);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        plan_instr(SW, 6'h0, 1'b0, 0, 5);
        foreach (plan[i]) begin
            if (i == 6) break;
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL rst_mid cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; rst = 1'b1; #1; n_chk++;
        if (got !== outs_t'('0))
            $display("FAIL rst_mid_async got %h want %h", got, 18'h0);
        else n_pass++;
        do_reset();
        plan_instr(LW, 6'h0, 1'b0, 0, 1);
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL rst_mid_after cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[6] = '{LW, SW, RT, ADDI, BEQ, J};
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h2a, 6'h1c, 6'h00};
        do_reset();
        for (int k = 0; k < 40; k++) begin
            logic [5:0] fn = fns[$urandom_range(4)];
            if ($urandom_range(4) == 0) fn = r6();
            plan_instr(ops[$urandom_range(5)], fn, r1(),
                       int'($urandom_range(2)), int'($urandom_range(3)));
        end
        foreach (plan[i]) begin
            drive(plan[i]); @(negedge clk); n_chk++;
            if (got !== plan[i].exp)
                $display("FAIL b2b cyc %0d got %h want %h", i, got, plan[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_sw_wait();
        test_fetch_timeout();
        test_memwr_timeout();
        test_illegal();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
